// File: rtl/gcc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcc_pkg
// Description : Shared defaults and the result record type used by the
//               gravity-center result collector and its FIFO.
//               Contents: GCC_COORD_W, GCC_IDX_W, gcc_result_t {idx, x, y}.
// Revision    : 1.0 - initial release
// ============================================================================
package gcc_pkg;

  localparam int GCC_COORD_W = 8;
  localparam int GCC_IDX_W   = 16;

  // One captured result, packed MSB-first as {idx, x, y}; the collector
  // stores exactly this layout in its FIFO.
  typedef struct packed {
    logic [GCC_IDX_W-1:0]   idx;
    logic [GCC_COORD_W-1:0] x;
    logic [GCC_COORD_W-1:0] y;
  } gcc_result_t;

endpackage : gcc_pkg
`default_nettype wire

// File: rtl/gcc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gcc_sync_fifo
// Description : Single-clock show-ahead FIFO. The head entry is visible on
//               dout combinationally whenever the FIFO is not empty.
// Ports       : CLK, RESET (async, active-high)
//               push/din  - write din at the tail (caller ensures !full||pop)
//               pop       - discard the head (caller ensures !empty)
//               dout      - head entry, forced to zero while empty
//               level     - occupancy 0..DEPTH; full / empty flags
// Revision    : 1.0 - initial release
// ============================================================================
module gcc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LVL_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  // Storage carries no reset; stale contents are masked on dout while empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers are power-of-two sized and wrap on their own.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign empty = (r_level == '0);
  assign full  = (r_level == LVL_W'(DEPTH));
  assign level = r_level;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule : gcc_sync_fifo
`default_nettype wire

// File: rtl/gcc_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : gcc_result_collector
// Description : Captures every (Xc, Yc) pair presented while READY_ is low,
//               tags it with a running index and buffers it for a
//               valid/ready consumer. Results arriving while the buffer is
//               full (and not being drained) are dropped and counted.
// Ports       : CLK, RESET (async, active-high)
//               READY_, Xc, Yc          - calculator result strobe/data
//               OUT_VALID/READY/X/Y/IDX - show-ahead consumer interface
//               LEVEL, FULL             - buffer occupancy
//               OVERFLOW, DROP_CNT      - sticky loss flag, saturating count
//               CLR_OVF                 - synchronous clear of loss status
// Revision    : 1.0 - initial release
// ============================================================================
module gcc_result_collector
  import gcc_pkg::*;
#(
  parameter int COORD_W = GCC_COORD_W,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = GCC_IDX_W,
  parameter int LVL_W   = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READY_,
  input  logic [COORD_W-1:0] Xc,
  input  logic [COORD_W-1:0] Yc,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [COORD_W-1:0] OUT_X,
  output logic [COORD_W-1:0] OUT_Y,
  output logic [IDX_W-1:0]   OUT_IDX,
  output logic [LVL_W-1:0]   LEVEL,
  output logic               FULL,
  output logic               OVERFLOW,
  output logic [IDX_W-1:0]   DROP_CNT,
  input  logic               CLR_OVF
);

  localparam int c_ENTRY_W = IDX_W + 2 * COORD_W;

  logic                 w_cap;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_empty;
  logic [c_ENTRY_W-1:0] w_din;
  logic [c_ENTRY_W-1:0] w_dout;

  logic [IDX_W-1:0]     r_idx_cnt;
  logic                 r_overflow;
  logic [IDX_W-1:0]     r_drop_cnt;

  assign w_cap  = ~READY_;
  assign w_pop  = OUT_VALID & OUT_READY;
  // A simultaneous pop frees a slot, so only a full FIFO with no pop drops.
  assign w_drop = w_cap & FULL & ~w_pop;
  assign w_push = w_cap & ~w_drop;
  assign w_din  = {r_idx_cnt, Xc, Yc};

  gcc_sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .level (LEVEL),
    .full  (FULL),
    .empty (w_empty)
  );

  assign OUT_VALID = ~w_empty;
  assign {OUT_IDX, OUT_X, OUT_Y} = w_dout;

  // Index advances on every capture, stored or dropped, so gaps mark losses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx_cnt <= '0;
    end else if (w_cap) begin
      r_idx_cnt <= r_idx_cnt + 1'b1;
    end
  end

  // A drop in the same cycle as CLR_OVF takes priority and restarts the count at 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (CLR_OVF) begin
        r_drop_cnt <= IDX_W'(1);
      end else if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end else if (CLR_OVF) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign OVERFLOW = r_overflow;
  assign DROP_CNT = r_drop_cnt;

endmodule : gcc_result_collector
`default_nettype wire

// File: tb/tb_gcc_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcc_result_collector
// Description : Self-checking bench for gcc_result_collector. A queue-based
//               reference model tracks buffered results, the running index
//               and the loss status; every cycle the DUT outputs are
//               compared against it, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcc_result_collector;
  import gcc_pkg::*;

  localparam int DEPTH = 16;

  logic        CLK;
  logic        RESET;
  logic        READY_;
  logic [7:0]  Xc;
  logic [7:0]  Yc;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  OUT_X;
  logic [7:0]  OUT_Y;
  logic [15:0] OUT_IDX;
  logic [4:0]  LEVEL;
  logic        FULL;
  logic        OVERFLOW;
  logic [15:0] DROP_CNT;
  logic        CLR_OVF;

  gcc_result_collector #(
    .COORD_W (8),
    .DEPTH   (DEPTH),
    .IDX_W   (16),
    .LVL_W   (5)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READY_    (READY_),
    .Xc        (Xc),
    .Yc        (Yc),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_X     (OUT_X),
    .OUT_Y     (OUT_Y),
    .OUT_IDX   (OUT_IDX),
    .LEVEL     (LEVEL),
    .FULL      (FULL),
    .OVERFLOW  (OVERFLOW),
    .DROP_CNT  (DROP_CNT),
    .CLR_OVF   (CLR_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  gcc_result_t m_q[$];
  logic [15:0] m_idx;
  logic        m_ovf;
  logic [15:0] m_drop;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_idx  = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  task automatic compare_all();
    gcc_result_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    check("valid",    {31'd0, OUT_VALID}, {31'd0, (m_q.size() != 0)});
    check("level",    {27'd0, LEVEL},     32'(m_q.size()));
    check("full",     {31'd0, FULL},      {31'd0, (m_q.size() == DEPTH)});
    check("overflow", {31'd0, OVERFLOW},  {31'd0, m_ovf});
    check("drop_cnt", {16'd0, DROP_CNT},  {16'd0, m_drop});
    check("out_x",    {24'd0, OUT_X},     {24'd0, h.x});
    check("out_y",    {24'd0, OUT_Y},     {24'd0, h.y});
    check("out_idx",  {16'd0, OUT_IDX},   {16'd0, h.idx});
  endtask

  // One clock: apply inputs, advance the model by the edge, then compare.
  task automatic cycle(input logic rdy_n, input logic [7:0] x, input logic [7:0] y,
                       input logic ordy, input logic clr);
    logic        mpop;
    logic        mfull;
    gcc_result_t e;
    READY_    = rdy_n;
    Xc        = x;
    Yc        = y;
    OUT_READY = ordy;
    CLR_OVF   = clr;
    @(posedge CLK);
    mpop  = (m_q.size() != 0) && ordy;
    mfull = (m_q.size() == DEPTH);
    if (mpop) void'(m_q.pop_front());
    if (!rdy_n && mfull && !mpop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
    end else begin
      if (clr) begin
        m_ovf  = 1'b0;
        m_drop = '0;
      end
      if (!rdy_n) begin
        e.idx = m_idx;
        e.x   = x;
        e.y   = y;
        m_q.push_back(e);
      end
    end
    if (!rdy_n) m_idx = m_idx + 16'd1;
    #1;
    compare_all();
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_level", {27'd0, LEVEL},     32'd0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    compare_all();
  endtask

  initial begin
    RESET     = 1'b1;
    READY_    = 1'b1;
    Xc        = '0;
    Yc        = '0;
    OUT_READY = 1'b0;
    CLR_OVF   = 1'b0;
    model_reset();
    #12;
    compare_all();
    check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single result, immediately consumable.
    cycle(1'b0, 8'h3A, 8'h51, 1'b1, 1'b0);
    check("first_x",   {24'd0, OUT_X},   32'h3A);
    check("first_y",   {24'd0, OUT_Y},   32'h51);
    check("first_idx", {16'd0, OUT_IDX}, 32'd0);
    cycle(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    check("first_drained", {27'd0, LEVEL}, 32'd0);

    // Fill to capacity with no consumer.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'(i), ~8'(i), 1'b0, 1'b0);
    check("fill_full",  {31'd0, FULL},     32'd1);
    check("fill_level", {27'd0, LEVEL},    32'd16);
    check("fill_ovf",   {31'd0, OVERFLOW}, 32'd0);

    // Three drops while full.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'hEE, 8'hEE, 1'b0, 1'b0);
    check("drop_ovf", {31'd0, OVERFLOW}, 32'd1);
    check("drop_cnt3", {16'd0, DROP_CNT}, 32'd3);

    // Capture and pop together while full: no drop, level stays, new index 19.
    check("head_before", {16'd0, OUT_IDX}, 32'd0);
    cycle(1'b0, 8'h77, 8'h88, 1'b1, 1'b0);
    check("pp_level", {27'd0, LEVEL},    32'd16);
    check("pp_drop",  {16'd0, DROP_CNT}, 32'd3);
    check("pp_head",  {16'd0, OUT_IDX},  32'd1);

    // Clear collides with a drop: the drop wins.
    cycle(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
    check("clr_ovf",  {31'd0, OVERFLOW}, 32'd1);
    check("clr_cnt",  {16'd0, DROP_CNT}, 32'd1);

    // Drain everything; last entry must be the index-19 capture.
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    check("tail_idx", {16'd0, OUT_IDX}, 32'd19);
    check("tail_x",   {24'd0, OUT_X},   32'h77);
    cycle(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    check("cleared_ovf", {31'd0, OVERFLOW}, 32'd0);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1,
            8'($urandom), 8'($urandom),
            ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 40 : 70)) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    // Reset mid-stream with 5 entries buffered.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'(i + 40), 8'(i + 80), 1'b0, 1'b0);
    check("pre_rst_level", {27'd0, LEVEL}, 32'd5);
    do_reset();
    cycle(1'b0, 8'hC3, 8'h3C, 1'b0, 1'b0);
    check("post_rst_idx", {16'd0, OUT_IDX}, 32'd0);
    check("post_rst_x",   {24'd0, OUT_X},   32'hC3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_gcc_result_collector
`default_nettype wire
